// File: rtl/spi_sclk_ctrl.sv
// SPI mode-3 frame/timing controller: drives CSn and SCLK for a burst of Num bytes
// and emits edge/byte strobes for the downstream Tx/Rx shifters.
module spi_sclk_ctrl #(
    parameter int DIV_HALF = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int BYTE_GAP = 1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Start,
    input  logic [7:0] Num,
    output logic       CSn,
    output logic       SCLK,
    output logic       H2L_Sig,
    output logic       L2H_Sig,
    output logic       Byte_En,
    output logic       Byte_Done,
    output logic       Busy,
    output logic       Done_Sig
);

    localparam int MAX_AB  = (DIV_HALF > CS_SETUP) ? DIV_HALF : CS_SETUP;
    localparam int MAX_CD  = (CS_HOLD > BYTE_GAP) ? CS_HOLD : BYTE_GAP;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_HALF - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_BSTART = 3'd2;
    localparam logic [2:0] ST_BIT_LO = 3'd3;
    localparam logic [2:0] ST_BIT_HI = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;
    localparam logic [2:0] ST_HOLD   = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       rem_reg, rem_next;

    logic csn_reg, sclk_reg, h2l_reg, l2h_reg, byte_en_reg, byte_done_reg, busy_reg, done_reg;
    logic csn_next, sclk_next, h2l_next, l2h_next, byte_en_next, byte_done_next, busy_next, done_next;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 1'b1;
        bit_next       = bit_reg;
        rem_next       = rem_reg;
        byte_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (Start && (Num != 8'd0)) begin
                    state_next = ST_SETUP;
                    rem_next   = Num;
                end
            end
            ST_SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    state_next = ST_BSTART;
                    cnt_next   = '0;
                end
            end
            ST_BSTART: begin
                state_next = ST_BIT_LO;
                cnt_next   = '0;
                bit_next   = 3'd0;
            end
            ST_BIT_LO: begin
                if (cnt_reg == DIV_LAST) begin
                    state_next = ST_BIT_HI;
                    cnt_next   = '0;
                end
            end
            ST_BIT_HI: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
                        // Counting down to zero means Num=255 never wraps the counter.
                        byte_done_next = 1'b1;
                        rem_next       = rem_reg - 8'd1;
                        state_next     = (rem_reg == 8'd1) ? ST_HOLD : ST_GAP;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        state_next = ST_BIT_LO;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_BSTART;
                    cnt_next   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end
            end
            ST_DONE: begin
                // Start is not sampled here, guaranteeing one Busy=0 cycle between frames.
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin changes in the same cycle as its strobe.
    always_comb begin
        csn_next     = (state_next == ST_IDLE) || (state_next == ST_DONE);
        sclk_next    = (state_next != ST_BIT_LO);
        h2l_next     = (state_next == ST_BIT_LO) && (state_reg != ST_BIT_LO);
        l2h_next     = (state_next == ST_BIT_HI) && (state_reg != ST_BIT_HI);
        byte_en_next = (state_next == ST_BSTART);
        busy_next    = (state_next != ST_IDLE);
        done_next    = (state_next == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_reg       <= 3'd0;
            rem_reg       <= 8'd0;
            csn_reg       <= 1'b1;
            sclk_reg      <= 1'b1;
            h2l_reg       <= 1'b0;
            l2h_reg       <= 1'b0;
            byte_en_reg   <= 1'b0;
            byte_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            rem_reg       <= rem_next;
            csn_reg       <= csn_next;
            sclk_reg      <= sclk_next;
            h2l_reg       <= h2l_next;
            l2h_reg       <= l2h_next;
            byte_en_reg   <= byte_en_next;
            byte_done_reg <= byte_done_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign CSn       = csn_reg;
    assign SCLK      = sclk_reg;
    assign H2L_Sig   = h2l_reg;
    assign L2H_Sig   = l2h_reg;
    assign Byte_En   = byte_en_reg;
    assign Byte_Done = byte_done_reg;
    assign Busy      = busy_reg;
    assign Done_Sig  = done_reg;

endmodule
